// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Every operation takes a fixed 34 cycles: one latch cycle, 32 shift-add or
// restoring-divide steps, and one fix-up cycle that writes the result.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic            accept;
    logic            finish;

    logic [CW-1:0]   count_reg;
    logic [2:0]      funct3_reg;
    logic [XLEN-1:0] opnd_reg;     // multiplicand or divisor magnitude
    logic [XLEN-1:0] hi_reg;       // product high half or partial remainder
    logic [XLEN-1:0] lo_reg;       // multiplier/product low half or dividend/quotient
    logic [XLEN-1:0] orig_a_reg;   // raw dividend, returned by REM on divide by zero
    logic            sign_a_reg;
    logic            sign_b_reg;
    logic            div_zero_reg;
    logic            done_reg;
    logic [XLEN-1:0] result_reg;

    // Sign/magnitude conversion of the two incoming operands
    logic [XLEN-1:0] op_in  [2];
    logic [XLEN-1:0] op_mag [2];
    logic            op_signed [2];
    logic            op_neg    [2];

    assign op_in[0] = operand_a;
    assign op_in[1] = operand_b;
    // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 only for MULH, DIV, REM
    assign op_signed[0] = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                          (funct3 == F_DIV)  || (funct3 == F_REM);
    assign op_signed[1] = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mag
            assign op_neg[gi] = op_signed[gi] & op_in[gi][XLEN-1];
            assign op_mag[gi] = op_neg[gi] ? -op_in[gi] : op_in[gi];
        end
    endgenerate

    // One iteration step: shift-add for multiply, restoring step for divide
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_diff;
    logic [XLEN-1:0] step_hi;
    logic [XLEN-1:0] step_lo;

    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
        div_shift = {hi_reg, lo_reg[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opnd_reg});
        // The true difference is below 2^XLEN whenever div_ge holds
        div_diff  = div_shift[XLEN-1:0] - opnd_reg;
        step_hi   = mul_sum[XLEN:1];
        step_lo   = {mul_sum[0], lo_reg[XLEN-1:1]};
        if (funct3_reg[2]) begin
            step_hi = div_ge ? div_diff : div_shift[XLEN-1:0];
            step_lo = {lo_reg[XLEN-2:0], div_ge};
        end
    end

    // Sign correction and special-case selection for the final result
    logic [2*XLEN-1:0] prod_raw;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_value;

    always_comb begin
        prod_raw  = {hi_reg, lo_reg};
        prod_fix  = (sign_a_reg ^ sign_b_reg) ? -prod_raw : prod_raw;
        quo_fix   = (sign_a_reg ^ sign_b_reg) ? -lo_reg : lo_reg;
        rem_fix   = sign_a_reg ? -hi_reg : hi_reg;
        fix_value = lo_reg;
        case (funct3_reg)
            // MUL has no sign flags, so prod_fix equals the raw product here
            F_MUL:                     fix_value = prod_fix[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU: fix_value = prod_fix[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:             fix_value = div_zero_reg ? '1 : quo_fix;
            F_REM, F_REMU:             fix_value = div_zero_reg ? orig_a_reg : rem_fix;
            default:                   fix_value = lo_reg;
        endcase
    end

    // Next-state logic; flush overrides everything, including a new start
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (count_reg == CW'(XLEN - 1)) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                finish     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (flush) begin
            state_next = S_IDLE;
            accept     = 1'b0;
            finish     = 1'b0;
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand latch, iteration datapath and registered result/done
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_reg    <= '0;
            funct3_reg   <= '0;
            opnd_reg     <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            orig_a_reg   <= '0;
            sign_a_reg   <= 1'b0;
            sign_b_reg   <= 1'b0;
            div_zero_reg <= 1'b0;
            done_reg     <= 1'b0;
            result_reg   <= '0;
        end else begin
            done_reg <= finish;
            if (finish) begin
                result_reg <= fix_value;
            end
            if (accept) begin
                funct3_reg   <= funct3;
                orig_a_reg   <= operand_a;
                sign_a_reg   <= op_neg[0];
                sign_b_reg   <= op_neg[1];
                div_zero_reg <= (operand_b == '0);
                opnd_reg     <= funct3[2] ? op_mag[1] : op_mag[0];
                lo_reg       <= funct3[2] ? op_mag[0] : op_mag[1];
                hi_reg       <= '0;
                count_reg    <= '0;
            end else if (state_reg == S_RUN) begin
                hi_reg    <= step_hi;
                lo_reg    <= step_lo;
                count_reg <= count_reg + CW'(1);
            end
        end
    end

    assign busy   = (state_reg != S_IDLE);
    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against a
// cycle-level behavioural model built from plain 64-bit arithmetic.
module tb_muldiv_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .start     (start),
        .flush     (flush),
        .funct3    (funct3),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 CLK = ~CLK;

    // Reference RV32M semantics computed with wide integer arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        int          ia;
        int          ib;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ub = longint'({32'd0, b});
        ia = signed'(a);
        ib = signed'(b);
        p  = '0;
        case (f3)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return ia / ib;
            end
            3'd5: begin
                if (b == 0) return 32'hFFFFFFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                return ia % ib;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Cycle-level model: an accepted operation completes 33 edges later
    logic        exp_busy    = 1'b0;
    logic        exp_done    = 1'b0;
    logic        model_valid = 1'b0;
    logic [31:0] exp_result  = '0;
    logic [31:0] pending     = '0;
    int          remaining   = 0;

    initial forever begin
        @(posedge CLK);
        if (RESET) begin
            exp_busy    = 1'b0;
            exp_done    = 1'b0;
            exp_result  = '0;
            remaining   = 0;
            model_valid = 1'b1;
        end else if (flush) begin
            exp_busy = 1'b0;
            exp_done = 1'b0;
        end else if (exp_busy) begin
            remaining--;
            exp_done = 1'b0;
            if (remaining == 0) begin
                exp_busy   = 1'b0;
                exp_done   = 1'b1;
                exp_result = pending;
            end
        end else begin
            exp_done = 1'b0;
            if (start) begin
                exp_busy  = 1'b1;
                remaining = 33;
                pending   = ref_op(funct3, operand_a, operand_b);
            end
        end
    end

    // Every-cycle comparison of the DUT against the model
    initial forever begin
        @(negedge CLK);
        if (model_valid) begin
            check("cyc busy", 32'(busy), 32'(exp_busy));
            check("cyc done", 32'(done), 32'(exp_done));
            check("cyc result", result, exp_result);
        end
    end

    logic [31:0] last_exp = '0;

    // Start one operation and check latency, busy length and result
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input bit immediate, input int poke_at,
                          input string name);
        int edges;
        int busy_cycles;
        bit got_done;
        if (!immediate) @(negedge CLK);
        start     = 1'b1;
        funct3    = f3;
        operand_a = a;
        operand_b = b;
        @(negedge CLK);
        start       = 1'b0;
        funct3      = 3'($urandom);
        operand_a   = $urandom;
        operand_b   = $urandom;
        edges       = 0;
        busy_cycles = 0;
        got_done    = 1'b0;
        while (edges < 40) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            if (edges == poke_at) begin
                start     = 1'b1;
                funct3    = 3'($urandom);
                operand_a = $urandom;
                operand_b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge CLK);
            edges++;
        end
        start = 1'b0;
        check({name, " done seen"}, 32'(got_done), 32'd1);
        check({name, " latency"}, 32'(edges), 32'd33);
        check({name, " busy cycles"}, 32'(busy_cycles), 32'd33);
        check({name, " result"}, result, expv);
        last_exp = expv;
        $display("op %s f3=%0d a=%h b=%h result=%h expected=%h latency=%0d",
                 name, f3, a, b, result, expv, edges);
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int n;
        n = 0;
        repeat (cycles) begin
            @(negedge CLK);
            if (done) n++;
        end
        check(name, 32'(n), 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET     = 1'b1;
        start     = 1'b0;
        flush     = 1'b0;
        funct3    = '0;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(negedge CLK);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        RESET = 1'b0;

        // Literal pins on the model itself
        check("model MUL", ref_op(3'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
        check("model DIV", ref_op(3'd4, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
        check("model REM", ref_op(3'd6, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);

        // Directed operations with hand-computed results
        run_op(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, -1, "MUL");
        run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, -1, "MULH");
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, -1, "MULHU");
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1, "MULHSU");
        run_op(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, -1, "DIV");
        run_op(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, -1, "REM");
        run_op(3'd5, 32'd100,      32'd7,        32'd14,       1'b0, -1, "DIVU");
        run_op(3'd7, 32'd100,      32'd7,        32'd2,        1'b0, -1, "REMU");
        run_op(3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, -1, "DIV by 0");
        run_op(3'd6, 32'd5,        32'd0,        32'd5,        1'b0, -1, "REM by 0");
        run_op(3'd4, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1'b0, -1, "DIV neg by 0");
        run_op(3'd7, 32'h12345678, 32'd0,        32'h12345678, 1'b0, -1, "REMU by 0");
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, -1, "DIV ovf");
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, -1, "REM ovf");

        // Start while busy is ignored; only one done appears
        run_op(3'd0, 32'd1234, 32'd5678, 32'd7006652, 1'b0, 5, "MUL poked");
        expect_quiet("poke single done", 36);

        // Start in the done cycle: accepted immediately
        run_op(3'd5, 32'd1000, 32'd10, 32'd100, 1'b0, -1, "DIVU first");
        run_op(3'd0, 32'd3,    32'd4,  32'd12,  1'b1, -1, "MUL back2back");

        // Flush mid-divide
        @(negedge CLK);
        start     = 1'b1;
        funct3    = 3'd4;
        operand_a = 32'd999;
        operand_b = 32'd3;
        @(negedge CLK);
        start = 1'b0;
        repeat (9) @(negedge CLK);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        check("flush busy", 32'(busy), 32'd0);
        check("flush done", 32'(done), 32'd0);
        check("flush result", result, last_exp);
        $display("op flush busy=%b done=%b result=%h", busy, done, result);
        expect_quiet("flush no done", 40);
        run_op(3'd7, 32'd50, 32'd8, 32'd2, 1'b0, -1, "REMU after flush");

        // Reset mid-multiply
        @(negedge CLK);
        start     = 1'b1;
        funct3    = 3'd3;
        operand_a = 32'hDEADBEEF;
        operand_b = 32'h01234567;
        @(negedge CLK);
        start = 1'b0;
        repeat (14) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset result", result, 32'd0);
        $display("op reset busy=%b done=%b result=%h", busy, done, result);
        expect_quiet("midreset no done", 40);

        // Flush and start together in IDLE
        @(negedge CLK);
        start     = 1'b1;
        flush     = 1'b1;
        funct3    = 3'd0;
        operand_a = 32'd9;
        operand_b = 32'd9;
        @(negedge CLK);
        start = 1'b0;
        flush = 1'b0;
        check("flush+start busy", 32'(busy), 32'd0);
        $display("op flush+start busy=%b", busy);
        expect_quiet("flush+start no done", 40);

        // Randomized operations, some issued back to back
        for (int i = 0; i < 150; i++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] b;
            f3 = 3'($urandom);
            a  = pick();
            b  = pick();
            run_op(f3, a, b, ref_op(f3, a, b), 1'($urandom_range(0, 1)), -1, "rand");
        end

        repeat (3) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
